// File: rtl/dilithium_lr_sequencer.sv
// Host-stream to low-resource Dilithium core sequencer: issues the ingest/execute/dump
// opcode sequences for keygen, verify and sign, with byte-exact message forwarding.
module dilithium_lr_sequencer #(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 32,
  parameter int PK_WORDS  = 328,
  parameter int SK_WORDS  = 640,
  parameter int SIG_WORDS = 605,
  parameter int TIMEOUT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [3:0]        core_op,
  output logic              core_op_valid,
  input  logic              core_idle,
  output logic              core_din_valid,
  input  logic              core_din_ready,
  output logic [DATA_W-1:0] core_din,
  output logic              core_din_last,
  input  logic              core_dout_valid,
  output logic              core_dout_ready,
  input  logic [DATA_W-1:0] core_dout
);
  localparam int BYTES     = DATA_W / 8;
  localparam int MAX_PS    = (PK_WORDS > SK_WORDS) ? PK_WORDS : SK_WORDS;
  localparam int MAX_WORDS = (MAX_PS > SIG_WORDS) ? MAX_PS : SIG_WORDS;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [3:0] OP_ING_PK   = 4'b1100, OP_ING_SK   = 4'b1101,
                         OP_ING_SIG  = 4'b1110, OP_ING_SEED = 4'b1111,
                         OP_DUMP_PK  = 4'b1000, OP_DUMP_SK  = 4'b1001,
                         OP_DUMP_SIG = 4'b1010, OP_KEYGEN   = 4'b0111,
                         OP_DIGEST   = 4'b0001, OP_PRE_VER  = 4'b0101,
                         OP_VERIFY   = 4'b0100, OP_PRE_SIGN = 4'b0011,
                         OP_SIGN     = 4'b0010;

  typedef enum logic [3:0] {
    IDLE, ING_SEED, KG_EXEC, DUMP_SK, DUMP_PK, ING_PK, ING_SIG, PRE_VER,
    MSG_LEN, MSG, EXEC_VER, VER_OUT, ING_SK, PRE_SIGN, EXEC_SIGN, DUMP_SIG
  } state_t;

  state_t             state_q, state_d;
  logic               blank_q, err_q, sk_loaded_q, sign_q, res_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   wcnt_q, dump_tgt;
  logic [WD_W-1:0]    wd_q;
  logic               idle_ok, dump_full, last_en, s_hs, m_hs, dout_hs, wd_fire;
  logic               err_start, set_sk, clr_sk, done_c, err_c;

  assign dump_tgt  = (state_q == DUMP_PK) ? CNT_W'(PK_WORDS) :
                     (state_q == DUMP_SK) ? CNT_W'(SK_WORDS) : CNT_W'(SIG_WORDS);
  assign dump_full = (wcnt_q == dump_tgt);
  assign last_en   = (state_q == DUMP_PK) || (state_q == DUMP_SIG);
  // Core idle is stale for one cycle after an opcode: the core has not latched it yet.
  assign idle_ok   = core_idle && !blank_q;
  assign s_hs      = s_valid && s_ready;
  assign m_hs      = m_valid && m_ready;
  assign dout_hs   = core_dout_valid && core_dout_ready;
  assign wd_fire   = (TIMEOUT != 0) && (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT));
  assign busy      = (state_q != IDLE);
  assign done      = (done_c || err_q) && !rst;
  assign error     = (err_c || err_q) && !rst;

  always_comb begin
    state_d = state_q; core_op = '0; core_op_valid = 1'b0;
    done_c = 1'b0; err_c = 1'b0; err_start = 1'b0; set_sk = 1'b0; clr_sk = 1'b0;
    s_ready = 1'b0; core_din_valid = 1'b0; core_din = s_data; core_din_last = 1'b0;
    m_valid = 1'b0; m_data = core_dout; m_last = 1'b0; core_dout_ready = 1'b0;

    if (state_q inside {ING_SEED, ING_PK, ING_SIG, ING_SK}) begin
      core_din_valid = s_valid;
      s_ready        = core_din_ready;
    end
    // Stop passing core words once the expected count is reached.
    if (state_q inside {DUMP_SK, DUMP_PK, DUMP_SIG} && !dump_full) begin
      m_valid         = core_dout_valid;
      core_dout_ready = m_ready;
      m_last          = core_dout_valid && last_en && (wcnt_q == dump_tgt - CNT_W'(1));
    end

    case (state_q)
      IDLE: if (start) begin
        case (mode)
          2'd0: begin state_d = ING_SEED; core_op = OP_ING_SEED; core_op_valid = 1'b1; end
          2'd1: begin state_d = ING_PK;   core_op = OP_ING_PK;   core_op_valid = 1'b1; end
          2'd2: begin state_d = ING_SK;   core_op = OP_ING_SK;   core_op_valid = 1'b1; end
          default:
            if (sk_loaded_q) begin
              state_d = PRE_SIGN; core_op = OP_PRE_SIGN; core_op_valid = 1'b1;
            end else err_start = 1'b1;
        endcase
      end
      ING_SEED: if (idle_ok) begin state_d = KG_EXEC; core_op = OP_KEYGEN;   core_op_valid = 1'b1; end
      KG_EXEC:  if (idle_ok) begin state_d = DUMP_SK; core_op = OP_DUMP_SK;  core_op_valid = 1'b1; end
      DUMP_SK:  if (dump_full && idle_ok) begin
        state_d = DUMP_PK; core_op = OP_DUMP_PK; core_op_valid = 1'b1;
      end
      DUMP_PK:  if (dump_full && idle_ok) begin state_d = IDLE; done_c = 1'b1; set_sk = 1'b1; end
      ING_PK:   if (idle_ok) begin state_d = ING_SIG; core_op = OP_ING_SIG;  core_op_valid = 1'b1; end
      ING_SIG:  if (idle_ok) begin state_d = PRE_VER; core_op = OP_PRE_VER;  core_op_valid = 1'b1; end
      PRE_VER:  if (idle_ok) state_d = MSG_LEN;
      ING_SK:   if (idle_ok) begin state_d = PRE_SIGN; core_op = OP_PRE_SIGN; core_op_valid = 1'b1; end
      PRE_SIGN: if (idle_ok) begin state_d = MSG_LEN; set_sk = 1'b1; end
      MSG_LEN: begin
        s_ready = 1'b1;
        if (s_valid) begin state_d = MSG; core_op = OP_DIGEST; core_op_valid = 1'b1; end
      end
      MSG: begin
        if (len_q != '0) begin
          core_din_valid = s_valid;
          s_ready        = core_din_ready;
          core_din_last  = (len_q <= LEN_W'(BYTES));
        end else if (idle_ok) begin
          state_d       = sign_q ? EXEC_SIGN : EXEC_VER;
          core_op       = sign_q ? OP_SIGN : OP_VERIFY;
          core_op_valid = 1'b1;
        end
      end
      EXEC_VER: begin
        core_dout_ready = 1'b1;
        if (idle_ok) state_d = VER_OUT;
      end
      VER_OUT: begin
        m_valid = 1'b1;
        m_data  = {{(DATA_W-1){1'b0}}, res_q};
        m_last  = 1'b1;
        if (m_ready) begin state_d = IDLE; done_c = 1'b1; end
      end
      EXEC_SIGN: if (idle_ok) begin state_d = DUMP_SIG; core_op = OP_DUMP_SIG; core_op_valid = 1'b1; end
      DUMP_SIG:  if (dump_full && idle_ok) begin state_d = IDLE; done_c = 1'b1; end
      default: state_d = IDLE;
    endcase

    if (wd_fire) begin
      state_d = IDLE; done_c = 1'b1; err_c = 1'b1; clr_sk = 1'b1; set_sk = 1'b0;
      core_op = '0; core_op_valid = 1'b0; s_ready = 1'b0; core_din_valid = 1'b0;
      core_din_last = 1'b0; m_valid = 1'b0; m_last = 1'b0; core_dout_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE; blank_q <= 1'b0; err_q <= 1'b0; sk_loaded_q <= 1'b0;
      sign_q <= 1'b0; res_q <= 1'b0; len_q <= '0; wcnt_q <= '0; wd_q <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= core_op_valid;
      err_q   <= err_start;
      if (clr_sk)      sk_loaded_q <= 1'b0;
      else if (set_sk) sk_loaded_q <= 1'b1;
      if (state_q == IDLE && start) sign_q <= mode[1];
      if (state_q == EXEC_VER && dout_hs) res_q <= core_dout[0];
      if (state_q == MSG_LEN && s_hs) len_q <= s_data[LEN_W-1:0];
      else if (state_q == MSG && s_hs)
        len_q <= (len_q > LEN_W'(BYTES)) ? len_q - LEN_W'(BYTES) : '0;
      if (state_d != state_q) wcnt_q <= '0;
      else if (m_hs)          wcnt_q <= wcnt_q + CNT_W'(1);
      if (state_d != state_q || s_hs || m_hs || dout_hs) wd_q <= '0;
      else if (state_q != IDLE && TIMEOUT != 0)          wd_q <= wd_q + WD_W'(1);
    end
  end
endmodule

// File: doc/dilithium_lr_sequencer.md
Name: dilithium_lr_sequencer

Overview:
- Parametrised next-generation sequencer between the streaming host interface (start/mode plus valid/ready data in and out) and the low-resource Dilithium core's opcode and data interface.
- Issues the ingest, execute and dump opcode sequence for keygen, verify and sign.
- Beyond the previous adapter it adds:
  - generic bus width;
  - byte-exact message length handling with a core-side last flag;
  - counted dumps with an m_last output;
  - a sign mode that reuses an already-resident secret key;
  - a watchdog error path.

Parameters:
DATA_W, 32, host/core data width in bits; multiple of 32. BYTES = DATA_W/8.
LEN_W, 32, message-length field width in bytes.
PK_WORDS, 328, pk dump length in DATA_W words.
SK_WORDS, 640, sk dump length in words.
SIG_WORDS, 605, signature dump length in words.
TIMEOUT, 0, max cycles in a core-wait state; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  sampled in IDLE only
mode  in  2  0 keygen, 1 verify, 2 sign, 3 sign reusing loaded sk
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at operation end
error  out  1  one-cycle pulse together with done on failure
s_valid/s_ready/s_data  in/out/in  1/1/DATA_W  host input stream
m_valid/m_ready/m_data/m_last  out/in/out/out  1/1/DATA_W/1  host output stream
core_op  out  4  opcode
core_op_valid  out  1  opcode strobe
core_idle  in  1  core idle / previous op complete
core_din_valid/core_din_ready/core_din/core_din_last  out/in/out/out  1/1/DATA_W/1  to core
core_dout_valid/core_dout_ready/core_dout  in/out/in  1/1/DATA_W  from core

Behaviour:
- Reset values:
  - state IDLE, busy 0, done 0, error 0, m_valid 0, m_last 0;
  - core_op 0, core_op_valid 0, core_din_valid 0, core_dout_ready 0, s_ready 0;
  - sk_loaded 0, all counters 0.
- Opcode encoding:
  - INGEST = {2'b11, sub}; DUMP = {2'b10, sub}; sub values: pk 00, sk 01, sig 10, seed 11.
  - KEYGEN 0111, DIGEST 0001, PRE_VERIFY 0101, VERIFY 0100, PRE_SIGN 0011, SIGN 0010.
- Opcode issue: core_op_valid is high for exactly the one cycle in which the FSM transitions into the state that the opcode starts. core_op is valid in that cycle only.
- Blanking: core_idle is ignored in the first cycle after any opcode issue. A state exits on the first core_idle=1 from the second cycle onward.
- Passthrough:
  - Ingest states (seed, pk, sig, sk) and MSG: core_din = s_data, core_din_valid = s_valid, s_ready = core_din_ready.
  - Dump states: m_data = core_dout, m_valid = core_dout_valid, core_dout_ready = m_ready.
- Sequences:
  - keygen: ING_SEED -> KG_EXEC -> DUMP_SK -> DUMP_PK -> IDLE. Sets sk_loaded on completion.
  - verify: ING_PK -> ING_SIG -> PRE_VER -> MSG_LEN -> MSG -> EXEC_VER -> VER_OUT -> IDLE.
  - sign: ING_SK -> PRE_SIGN -> MSG_LEN -> MSG -> EXEC_SIGN -> DUMP_SIG -> IDLE. Sets sk_loaded at PRE_SIGN exit.
  - mode 3 with sk_loaded=1: start goes directly to MSG_LEN via PRE_SIGN issue. With sk_loaded=0: done=error=1 next cycle, stays IDLE, no opcode issued.
- MSG_LEN:
  - s_ready=1; on handshake, load len_ctr = s_data[LEN_W-1:0] and issue DIGEST.
  - Enter MSG; this word is not forwarded to the core.
- MSG:
  - Forward words while len_ctr != 0. Each handshake: len_ctr -= min(len_ctr, BYTES), saturating at 0.
  - core_din_last = (len_ctr <= BYTES).
  - When len_ctr == 0: s_ready=0, core_din_valid=0, wait core_idle, then issue SIGN or VERIFY.
  - Length 0 means no data words are forwarded.
- Dumps:
  - A word counter counts m handshakes against PK_WORDS, SK_WORDS or SIG_WORDS.
  - The next dump opcode, or exit, follows the final handshake and core_idle.
  - m_last=1 only on the final word of DUMP_PK and DUMP_SIG. It is 0 on the final word of DUMP_SK.
- EXEC_VER:
  - m_valid=0; capture res = core_dout[0] on core_dout_valid, with core_dout_ready=1.
  - Go to VER_OUT on core_idle.
- VER_OUT:
  - m_valid=1, m_data = {0, res}, m_last=1.
  - On m_ready: done=1, return to IDLE.
- done is a one-cycle pulse on the final transition to IDLE.
- Watchdog:
  - The counter clears on every state change and every data handshake.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT: done=error=1, go to IDLE, clear sk_loaded, drop all valids.
- start while busy is ignored. mode is sampled only on the start cycle.
- rst mid-operation returns all outputs to reset values on the next edge. No partial done is produced.

Test Plan:
- Keygen, core_idle 5 cycles after each op: opcodes 1111, 0111, 1001, 1000 in order. 640 sk words then 328 pk words on m. m_last only on pk word 328. One done pulse.
- Verify with length 9 bytes: s words = len, w0, w1, w2. core_din_last on w2 only. s_ready=0 afterwards. Core result 1 -> m_data=1, m_last=1, done=1, error=0.
- Sign with length 0: DIGEST is followed by SIGN with no core_din_valid. 605 sig words, m_last on the last. sk_loaded=1 afterwards.
- Mode 3 after reset -> done=error=1 with no core_op_valid. Mode 3 after a completed sign -> first opcode is PRE_SIGN (0011), no sk ingest.
- TIMEOUT=20, core_idle stuck low in KG_EXEC -> error and done on cycle 20, busy=0 on the following cycle.
- Backpressure: m_ready toggling 1/0 during DUMP_SIG -> no word dropped or duplicated, counter exact. rst asserted mid-MSG -> IDLE next cycle, busy=0, all valids 0.
